// File: rtl/wvb_rd_arb_pkg.sv
// Shared types and widths for the waveform-buffer read arbiter.
package wvb_rd_arb_pkg;

    localparam int unsigned ChanIdxW  = 8;
    localparam int unsigned DpramLenW = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2,
        S_HOST = 2'd3
    } arb_state_e;

endpackage

// File: rtl/wvb_rd_arbiter_rr_prio_enc.sv
// Rotating priority encoder: first set request bit searching upward from last_grant+1, wrapping.
module rr_prio_enc
    import wvb_rd_arb_pkg::*;
#(
    parameter int unsigned P_N_CHAN = 24
) (
    input  logic [P_N_CHAN-1:0] req,
    input  logic [ChanIdxW-1:0] last_grant,
    output logic [ChanIdxW-1:0] grant,
    output logic                valid
);

    // Walk candidates in priority order; the first hit wins.
    always_comb begin
        int unsigned cand;
        logic [P_N_CHAN-1:0] shifted;
        grant   = '0;
        valid   = 1'b0;
        cand    = 0;
        shifted = '0;
        for (int unsigned k = 1; k <= P_N_CHAN; k++) begin
            cand    = (int'(last_grant) + k) % P_N_CHAN;
            shifted = req >> cand;
            if (!valid && shifted[0]) begin
                valid = 1'b1;
                grant = ChanIdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// Round-robin scheduler sharing the waveform-buffer read controller among channels.
// Optional host-done watchdog enabled by defining WVB_RD_ARB_TIMEOUT_EN.
module wvb_rd_arbiter
    import wvb_rd_arb_pkg::*;
#(
    parameter int unsigned P_N_CHAN        = 24,
    parameter int unsigned P_TIMEOUT_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arb_en,
    input  logic [P_N_CHAN-1:0]   chan_en,
    input  logic [P_N_CHAN-1:0]   wvb_not_empty,
    input  logic                  dpram_mode_cfg,
    output logic                  rd_req,
    output logic [ChanIdxW-1:0]   rd_idx,
    output logic                  rd_dpram_mode,
    input  logic                  rd_ack,
    input  logic                  rd_more,
    input  logic [DpramLenW-1:0]  rd_len,
    output logic                  dpram_rdy,
    output logic [DpramLenW-1:0]  dpram_len,
    output logic [ChanIdxW-1:0]   dpram_chan,
    output logic                  dpram_more,
    input  logic                  dpram_done,
    output logic                  busy,
    output logic                  timeout
);

    arb_state_e            state_q, state_d;
    logic [ChanIdxW-1:0]   rd_idx_q, rd_idx_d;
    logic                  mode_q, mode_d;
    logic [DpramLenW-1:0]  len_q, len_d;
    logic                  more_q, more_d;
    logic [ChanIdxW-1:0]   chan_q, chan_d;
    logic [ChanIdxW-1:0]   last_q, last_d;
    logic [P_N_CHAN-1:0]   eligible;
    logic [ChanIdxW-1:0]   grant_idx;
    logic                  grant_valid;
    logic                  host_done;

    assign eligible = wvb_not_empty & chan_en;

    rr_prio_enc #(
        .P_N_CHAN (P_N_CHAN)
    ) u_prio_enc (
        .req        (eligible),
        .last_grant (last_q),
        .grant      (grant_idx),
        .valid      (grant_valid)
    );

`ifdef WVB_RD_ARB_TIMEOUT_EN
    logic [P_TIMEOUT_WIDTH-1:0] wd_cnt_q;
    logic                       timeout_q;
    logic                       wd_fire;

    assign wd_fire = (state_q == S_HOST) && (wd_cnt_q == '1);

    // Watchdog: counts only in S_HOST, so it is zero on every entry; flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != S_HOST) begin
                wd_cnt_q <= '0;
            end else if (!wd_fire) begin
                wd_cnt_q <= wd_cnt_q + P_TIMEOUT_WIDTH'(1);
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign host_done = dpram_done | wd_fire;
    assign timeout   = timeout_q;
`else
    assign host_done = dpram_done;
    assign timeout   = 1'b0;
`endif

    // Next-state and latch updates for grant, fragment handoff and event completion.
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        mode_d   = mode_q;
        len_d    = len_q;
        more_d   = more_q;
        chan_d   = chan_q;
        last_d   = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_en && grant_valid) begin
                    rd_idx_d = grant_idx;
                    mode_d   = dpram_mode_cfg;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    len_d   = rd_len;
                    more_d  = rd_more;
                    chan_d  = rd_idx_q;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!rd_ack) begin
                    state_d = S_HOST;
                end
            end
            S_HOST: begin
                if (host_done) begin
                    if (more_q) begin
                        state_d = S_REQ;
                    end else begin
                        // Round-robin pointer moves only once the whole event is done.
                        last_d  = rd_idx_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched event/fragment registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rd_idx_q <= '0;
            mode_q   <= 1'b0;
            len_q    <= '0;
            more_q   <= 1'b0;
            chan_q   <= '0;
            last_q   <= ChanIdxW'(P_N_CHAN - 1);
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            more_q   <= more_d;
            chan_q   <= chan_d;
            last_q   <= last_d;
        end
    end

    assign rd_req        = (state_q == S_REQ);
    assign dpram_rdy     = (state_q == S_HOST);
    assign busy          = (state_q != S_IDLE);
    assign rd_idx        = rd_idx_q;
    assign rd_dpram_mode = mode_q;
    assign dpram_len     = len_q;
    assign dpram_chan    = chan_q;
    assign dpram_more    = more_q;

endmodule
